decode_execute_register: RTL and testbench

//  Decode->Execute pipeline register, directly downstream of register_file.

---
 rtl/decode_execute_register_pkg.sv | 43 ++++
 rtl/decode_execute_register_if.sv | 45 ++++
 rtl/decode_execute_register.sv | 72 +++++++
 tb/tb_decode_execute_register.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_execute_register_pkg.sv
// Shared types and constants for the decode->execute pipeline register.
package decode_execute_pkg;

  localparam int unsigned N     = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic [3:0] alu_control;
    logic       alu_src;
    logic       branch;
    logic [1:0] flag_write;
    logic       vec_op;
  } ctrl_t;

  localparam ctrl_t         CTRL_NOP = '0;
  localparam logic [AW-1:0] REG_ZERO = 5'd0;
  localparam logic [AW-1:0] REG_PC   = 5'd15;

  // Everything the E stage holds for one instruction
  typedef struct packed {
    logic          valid;
    ctrl_t         ctrl;
    logic [N-1:0]  rd1;
    logic [N-1:0]  rd2;
    logic [N-1:0]  pc_plus8;
    logic [N-1:0]  ext_imm;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [AW-1:0] wa3;
  } estage_t;

  // A writeback may repair an operand only for scalar, non-$zero registers
  function automatic logic wb_hit(input logic          we,
                                  input logic [AW-1:0] wa,
                                  input logic [AW-1:0] ra);
    return we && (wa == ra) && (ra != REG_ZERO) && !ra[AW-1];
  endfunction

endpackage

// File: rtl/decode_execute_register_if.sv
// Decode/writeback inputs and execute-stage outputs of the D->E pipeline register.
interface decode_execute_register_if;
  import decode_execute_pkg::*;

  logic                StallE;
  logic                FlushE;
  logic                ValidD;
  ctrl_t               CtrlD;
  logic [N-1:0]        RD1D;
  logic [N-1:0]        RD2D;
  logic [N-1:0]        PCPlus8D;
  logic [N-1:0]        ExtImmD;
  logic [AW-1:0]       RA1D;
  logic [AW-1:0]       RA2D;
  logic [AW-1:0]       WA3D;
  logic                RegWriteW;
  logic [AW-1:0]       WA3W;
  logic [N-1:0]        ResultW;

  logic                ValidE;
  ctrl_t               CtrlE;
  logic [N-1:0]        RD1E;
  logic [N-1:0]        RD2E;
  logic [N-1:0]        PCPlus8E;
  logic [N-1:0]        ExtImmE;
  logic [AW-1:0]       RA1E;
  logic [AW-1:0]       RA2E;
  logic [AW-1:0]       WA3E;
  logic [CNT_W-1:0]    FlushCnt;

  modport master (
    output StallE, FlushE, ValidD, CtrlD, RD1D, RD2D, PCPlus8D, ExtImmD,
           RA1D, RA2D, WA3D, RegWriteW, WA3W, ResultW,
    input  ValidE, CtrlE, RD1E, RD2E, PCPlus8E, ExtImmE, RA1E, RA2E, WA3E,
           FlushCnt
  );

  modport slave (
    input  StallE, FlushE, ValidD, CtrlD, RD1D, RD2D, PCPlus8D, ExtImmD,
           RA1D, RA2D, WA3D, RegWriteW, WA3W, ResultW,
    output ValidE, CtrlE, RD1E, RD2E, PCPlus8E, ExtImmE, RA1E, RA2E, WA3E,
           FlushCnt
  );

endinterface

// File: rtl/decode_execute_register.sv
// Decode->Execute pipeline register with stall, flush, saturating flush counter.
// Optional writeback bypass of RD1/RD2 when WB_BYPASS_EN is defined.
module decode_execute_register
  import decode_execute_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  decode_execute_register_if.slave  de
);

  estage_t          e_q, e_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-value mux: flush > stall > capture
  always_comb begin
    e_d   = e_q;
    cnt_d = cnt_q;
    if (de.FlushE) begin
      e_d = '0;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end else if (de.StallE) begin
`ifdef WB_BYPASS_EN
      if (e_q.valid) begin
        if (wb_hit(de.RegWriteW, de.WA3W, e_q.ra1)) e_d.rd1 = de.ResultW;
        if (wb_hit(de.RegWriteW, de.WA3W, e_q.ra2)) e_d.rd2 = de.ResultW;
      end
`endif
    end else begin
      e_d.valid    = de.ValidD;
      e_d.ctrl     = de.ValidD ? de.CtrlD : CTRL_NOP;
      e_d.rd1      = de.RD1D;
      e_d.rd2      = de.RD2D;
      e_d.pc_plus8 = de.PCPlus8D;
      e_d.ext_imm  = de.ExtImmD;
      e_d.ra1      = de.RA1D;
      e_d.ra2      = de.RA2D;
      e_d.wa3      = de.WA3D;
`ifdef WB_BYPASS_EN
      // Writeback landing in the same cycle the register file was read
      if (wb_hit(de.RegWriteW, de.WA3W, de.RA1D)) e_d.rd1 = de.ResultW;
      if (wb_hit(de.RegWriteW, de.WA3W, de.RA2D)) e_d.rd2 = de.ResultW;
`endif
    end
  end

`ifndef WB_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{de.RegWriteW, de.WA3W, de.ResultW};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      cnt_q <= cnt_d;
    end
  end

  assign de.ValidE   = e_q.valid;
  assign de.CtrlE    = e_q.ctrl;
  assign de.RD1E     = e_q.rd1;
  assign de.RD2E     = e_q.rd2;
  assign de.PCPlus8E = e_q.pc_plus8;
  assign de.ExtImmE  = e_q.ext_imm;
  assign de.RA1E     = e_q.ra1;
  assign de.RA2E     = e_q.ra2;
  assign de.WA3E     = e_q.wa3;
  assign de.FlushCnt = cnt_q;

endmodule

// File: tb/tb_decode_execute_register.sv
// Scoreboard bench for decode_execute_register: random + directed stimulus against a
// behavioural model; honours WB_BYPASS_EN the same way the design does.
module tb_decode_execute_register;
  import decode_execute_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [11:0] ctrl;
    logic [31:0] rd1, rd2, pc8, imm;
    logic [4:0]  ra1, ra2, wa3;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decode_execute_register_if dif();
  decode_execute_register dut (.clk(clk), .rst(rst), .de(dif));

  exp_t m;
  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  bit   done   = 1'b0;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passes++;
  endtask

  // A writeback repairs only scalar registers 1..15
  function automatic bit repairs(input logic [4:0] a);
    return BYP && dif.RegWriteW && (dif.WA3W == a) && (a != 0) && (a < 16);
  endfunction

  // Reference model: apply one clock edge's worth of rules to m
  task automatic model_step();
    if (!rst) m = '0;
    else if (dif.FlushE) begin
      m.valid = 0; m.ctrl = '0; m.rd1 = '0; m.rd2 = '0; m.pc8 = '0; m.imm = '0;
      m.ra1 = '0; m.ra2 = '0; m.wa3 = '0;
      if (m.cnt < 16'hFFFF) m.cnt = m.cnt + 16'd1;
    end else if (dif.StallE) begin
      if (m.valid) begin
        if (repairs(m.ra1)) m.rd1 = dif.ResultW;
        if (repairs(m.ra2)) m.rd2 = dif.ResultW;
      end
    end else begin
      m.valid = dif.ValidD;
      m.ctrl  = dif.ValidD ? 12'(dif.CtrlD) : 12'h000;
      m.rd1   = repairs(dif.RA1D) ? dif.ResultW : dif.RD1D;
      m.rd2   = repairs(dif.RA2D) ? dif.ResultW : dif.RD2D;
      m.pc8   = dif.PCPlus8D;
      m.imm   = dif.ExtImmD;
      m.ra1   = dif.RA1D;
      m.ra2   = dif.RA2D;
      m.wa3   = dif.WA3D;
    end
    q.push_back(m);
  endtask

  // One clock: predict, let the edge happen, return at the falling edge
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    dif.StallE = 0; dif.FlushE = 0; dif.ValidD = 0; dif.CtrlD = CTRL_NOP;
    dif.RD1D = '0; dif.RD2D = '0; dif.PCPlus8D = '0; dif.ExtImmD = '0;
    dif.RA1D = '0; dif.RA2D = '0; dif.WA3D = '0;
    dif.RegWriteW = 0; dif.WA3W = '0; dif.ResultW = '0;
  endtask

  task automatic rand_inputs(input bit allow_ctl);
    dif.ValidD    = ($urandom % 4) != 0;
    dif.CtrlD     = ctrl_t'(12'($urandom));
    dif.RD1D      = $urandom;
    dif.RD2D      = $urandom;
    dif.PCPlus8D  = $urandom;
    dif.ExtImmD   = $urandom;
    dif.RA1D      = 5'($urandom);
    dif.RA2D      = 5'($urandom);
    dif.WA3D      = 5'($urandom);
    dif.RegWriteW = ($urandom % 2) != 0;
    dif.ResultW   = $urandom;
    case ($urandom % 4)
      0: dif.WA3W = dif.RA1D;
      1: dif.WA3W = dif.RA2D;
      2: dif.WA3W = dut.e_q.ra1 ^ 5'($urandom % 2);
      default: dif.WA3W = 5'($urandom);
    endcase
    dif.StallE = allow_ctl && (($urandom % 4) == 0);
    dif.FlushE = allow_ctl && (($urandom % 8) == 0);
  endtask

  // Monitor: outputs are presented every cycle; compare against the queue head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("estage",
              256'({dif.ValidE, dif.CtrlE, dif.RD1E, dif.RD2E, dif.PCPlus8E, dif.ExtImmE,
                    dif.RA1E, dif.RA2E, dif.WA3E}),
              256'({e.valid, e.ctrl, e.rd1, e.rd2, e.pc8, e.imm, e.ra1, e.ra2, e.wa3}));
        check("flush_cnt", 256'(dif.FlushCnt), 256'(e.cnt));
      end
    end
  end

  initial begin
    #1_500_000;
    if (!done) begin
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
    end
  end

  initial begin
    m = '0;
    clear_inputs();
    @(negedge clk);

    // Reset held while inputs toggle
    rst = 0;
    repeat (2) begin rand_inputs(1'b1); step(); end
    check("reset_valid", 256'(dif.ValidE), 256'(0));
    check("reset_cnt",   256'(dif.FlushCnt), 256'(0));
    rst = 1;

    // Plain capture
    clear_inputs();
    dif.ValidD = 1; dif.RA1D = 5'd8; dif.RD1D = 32'h55; dif.WA3D = 5'd14; dif.PCPlus8D = 32'd8;
    step();
    check("cap_rd1", 256'(dif.RD1E), 256'(32'h55));
    check("cap_wa3", 256'(dif.WA3E), 256'(14));
    check("cap_pc8", 256'(dif.PCPlus8E), 256'(8));
    check("cap_valid", 256'(dif.ValidE), 256'(1));

    // Stall freezes while D side changes
    repeat (3) begin rand_inputs(1'b0); dif.RegWriteW = 0; dif.StallE = 1; step(); end
    check("stall_rd1", 256'(dif.RD1E), 256'(32'h55));
    check("stall_wa3", 256'(dif.WA3E), 256'(14));
    check("stall_pc8", 256'(dif.PCPlus8E), 256'(8));

    // Flush beats stall
    rand_inputs(1'b0); dif.StallE = 1; dif.FlushE = 1; step();
    check("sf_valid", 256'(dif.ValidE), 256'(0));
    check("sf_ctrl",  256'(dif.CtrlE), 256'(0));
    check("sf_wa3",   256'(dif.WA3E), 256'(0));

    // Bypass on capture, plus $zero and vector exclusions
    clear_inputs();
    dif.ValidD = 1; dif.RA1D = 5'd8; dif.RegWriteW = 1; dif.WA3W = 5'd8; dif.ResultW = 32'hCC;
    step();
    check("byp_scalar", 256'(dif.RD1E), 256'(BYP ? 32'hCC : 32'h0));
    dif.RA1D = 5'd0; dif.WA3W = 5'd0; step();
    check("byp_zero", 256'(dif.RD1E), 256'(0));
    dif.RA1D = 5'b11000; dif.WA3W = 5'b11000; step();
    check("byp_vector", 256'(dif.RD1E), 256'(0));

    // Bypass while stalled
    clear_inputs();
    dif.ValidD = 1; dif.RA1D = 5'd3; dif.RD1D = 32'hA1; dif.RA2D = 5'd14; dif.RD2D = 32'hB2;
    dif.WA3D = 5'd7; step();
    clear_inputs();
    dif.StallE = 1; dif.RegWriteW = 1; dif.WA3W = 5'd14; dif.ResultW = 32'h1234; step();
    check("stall_byp_rd2", 256'(dif.RD2E), 256'(BYP ? 32'h1234 : 32'hB2));
    check("stall_byp_rd1", 256'(dif.RD1E), 256'(32'hA1));
    check("stall_byp_wa3", 256'(dif.WA3E), 256'(7));

    // Random traffic with occasional reset pulses
    repeat (1500) begin
      rand_inputs(1'b1);
      rst = ($urandom % 40) != 0;
      step();
    end
    rst = 1;

    // Saturation: start from a clean count
    clear_inputs();
    rst = 0; step(); rst = 1;
    check("sat_start", 256'(dif.FlushCnt), 256'(0));
    dif.FlushE = 1;
    repeat (5) step();
    check("flush5", 256'(dif.FlushCnt), 256'(5));
    repeat (65529) step();
    check("flush_fffe", 256'(dif.FlushCnt), 256'(16'hFFFE));
    repeat (3) step();
    check("flush_sat", 256'(dif.FlushCnt), 256'(16'hFFFF));
    clear_inputs();
    step();
    @(posedge clk); #2;
    check("queue_drained", 256'(q.size()), 256'(0));

    done = 1'b1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
